// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op codes, FSM state encoding, default iteration count and magnitude helper for muldiv_hilo
package muldiv_pkg;
  localparam int ITER_DEF = 32;
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;
  function automatic logic [31:0] mag(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? -x : x;
  endfunction
endpackage

// File: rtl/muldiv_hilo_div_step.sv
// div_step: one restoring-divide iteration; ports rem_i/quo_i/dvs_i in, rem_o/quo_o out (quo_i shifts dividend bits in, quotient bits out)
module div_step (
  input  logic [31:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] dvs_i,
  output logic [31:0] rem_o,
  output logic [31:0] quo_o
);
  logic [32:0] trial;
  always_comb begin
    trial = {rem_i, quo_i[31]} - {1'b0, dvs_i};
    rem_o = trial[32] ? {rem_i[30:0], quo_i[31]} : trial[31:0];
    quo_o = {quo_i[30:0], ~trial[32]};
  end
endmodule

// File: rtl/muldiv_hilo.sv
// muldiv_hilo: iterative MIPS-style HI/LO multiply/divide unit; in clk rst_n start op a b, out busy done div0 hi lo; MULDIV_FAST_MUL_EN selects a single-cycle multiplier
module muldiv_hilo
  import muldiv_pkg::*;
#(
  parameter int ITER = ITER_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        div0,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int CW = $clog2(ITER + 1);
  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [63:0] acc_q, acc_d;
  logic        done_q, done_d, div0_q, div0_d;
  logic        accept, go, fast_in, sgn_in, div_in, sgn, is_div, neg, fix, dz;
  logic [31:0] ma, mb, rem_n, quo_n, fix_hi, fix_lo;
  logic [32:0] psum;
  logic [63:0] mprod, prod;
  div_step u_div_step (
    .rem_i(acc_q[63:32]),
    .quo_i(acc_q[31:0]),
    .dvs_i(mb),
    .rem_o(rem_n),
    .quo_o(quo_n)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      div0_q  <= div0_d;
    end
  end
  always_comb begin
    accept = start && state_q == S_IDLE && op <= OP_MTLO;
    go     = accept && op <= OP_DIVU;
`ifdef MULDIV_FAST_MUL_EN
    fast_in = op <= OP_MULTU;
`else
    fast_in = 1'b0;
`endif
    state_d = state_q == S_IDLE ? (go ? (fast_in ? S_FIX : S_RUN) : S_IDLE) :
              state_q == S_RUN  ? (cnt_q == CW'(ITER - 1) ? S_FIX : S_RUN) : S_IDLE;
    cnt_d   = state_q == S_RUN ? cnt_q + 1'b1 : '0;
  end
  always_comb begin
    sgn_in = op == OP_MULT || op == OP_DIV;
    div_in = op == OP_DIV || op == OP_DIVU;
    sgn    = op_q == OP_MULT || op_q == OP_DIV;
    is_div = op_q == OP_DIV || op_q == OP_DIVU;
    ma     = mag(a_q, sgn);
    mb     = mag(b_q, sgn);
    neg    = sgn && (a_q[31] ^ b_q[31]);
    fix    = state_q == S_FIX;
    dz     = is_div && b_q == '0;
    psum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, ma} : 33'd0);
`ifdef MULDIV_FAST_MUL_EN
    mprod  = {32'd0, ma} * {32'd0, mb};
`else
    mprod  = acc_q;
`endif
    prod   = neg ? -mprod : mprod;
    fix_hi = dz ? a_q : is_div ? ((sgn && a_q[31]) ? -acc_q[63:32] : acc_q[63:32]) : prod[63:32];
    fix_lo = dz ? '1 : is_div ? (neg ? -acc_q[31:0] : acc_q[31:0]) : prod[31:0];
    op_d   = go ? op : op_q;
    a_d    = go ? a : a_q;
    b_d    = go ? b : b_q;
    acc_d  = go ? {32'd0, mag(div_in ? a : b, sgn_in)} :
             state_q == S_RUN ? (is_div ? {rem_n, quo_n} : {psum, acc_q[31:1]}) : acc_q;
    hi_d   = fix ? fix_hi : (accept && op == OP_MTHI) ? a : hi_q;
    lo_d   = fix ? fix_lo : (accept && op == OP_MTLO) ? a : lo_q;
    done_d = fix;
    div0_d = accept ? 1'b0 : (fix && dz) ? 1'b1 : div0_q;
    busy   = state_q != S_IDLE;
    done   = done_q;
    div0   = div0_q;
    hi     = hi_q;
    lo     = lo_q;
  end
endmodule

// File: tb/tb_muldiv_hilo.sv
// tb_muldiv_hilo: table-driven and randomized self-checking bench for muldiv_hilo against an arithmetic reference model
module tb_muldiv_hilo;
  localparam int ITER = 32;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, div0;
  logic [31:0] hi, lo;
  int          n_tests = 0, n_fail = 0;
  logic [31:0] hi_m = '0, lo_m = '0;
  logic        d0_m = 1'b0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        d0;
  } vec_t;
  vec_t tbl[12];

  muldiv_hilo #(.ITER(ITER)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    longint unsigned ux, uy, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    if (o <= 3'd5) d0_m = (o == 3'd2 || o == 3'd3) && y == 0;
    if (o == 3'd0) begin
      p = longint'(sx * sy);
      {hi_m, lo_m} = p;
    end else if (o == 3'd1) begin
      p = ux * uy;
      {hi_m, lo_m} = p;
    end else if ((o == 3'd2 || o == 3'd3) && y == 0) begin
      hi_m = x;
      lo_m = 32'hFFFFFFFF;
    end else if (o == 3'd2) begin
      q = sx / sy;
      r = sx % sy;
      lo_m = q[31:0];
      hi_m = r[31:0];
    end else if (o == 3'd3) begin
      p = ux / uy;
      lo_m = p[31:0];
      p = ux % uy;
      hi_m = p[31:0];
    end else if (o == 3'd4) hi_m = x;
    else if (o == 3'd5) lo_m = x;
  endtask

  function automatic int exp_lat(input logic [2:0] o);
`ifdef MULDIV_FAST_MUL_EN
    return (o <= 3'd1) ? 1 : ITER + 1;
`else
    return (o <= 3'd1) ? ITER + 1 : ITER + 1;
`endif
  endfunction

  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] h0, l0;
    int lat;
    bit ok;
    h0 = hi_m;
    l0 = lo_m;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
    chk("div0_clear_on_start", {63'd0, div0}, 64'd0);
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    lat = 0;
    ok = 1'b1;
    while (!done && lat < 200) begin
      if (hi !== h0 || lo !== l0 || busy !== 1'b1) ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    model(o, x, y);
    chk("latency", 64'(lat), 64'(exp_lat(o)));
    chk("hold_while_busy", {63'd0, ok}, 64'd1);
    chk("hi", {32'd0, hi}, {32'd0, hi_m});
    chk("lo", {32'd0, lo}, {32'd0, lo_m});
    chk("div0", {63'd0, div0}, {63'd0, d0_m});
    chk("busy_at_done", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    chk("done_one_cycle", {63'd0, done}, 64'd0);
  endtask

  task automatic mt(input logic [2:0] o, input logic [31:0] x);
    @(negedge clk);
    start = 1'b1; op = o; a = x;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom;
    model(o, x, 32'd0);
    chk("mt_hi", {32'd0, hi}, {32'd0, hi_m});
    chk("mt_lo", {32'd0, lo}, {32'd0, lo_m});
    chk("mt_busy", {63'd0, busy}, 64'd0);
    chk("mt_div0", {63'd0, div0}, {63'd0, d0_m});
    @(posedge clk); #1;
    chk("mt_no_done", {63'd0, done}, 64'd0);
  endtask

  task automatic ign(input logic [2:0] o);
    @(negedge clk);
    start = 1'b1; op = o; a = $urandom; b = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ign_busy", {63'd0, busy}, 64'd0);
    chk("ign_hilo", {hi, lo}, {hi_m, lo_m});
    @(posedge clk); #1;
    chk("ign_no_done", {63'd0, done}, 64'd0);
  endtask

  initial begin
    tbl[0]  = '{3'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    tbl[1]  = '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    tbl[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    tbl[3]  = '{3'd2, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1};
    tbl[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0};
    tbl[5]  = '{3'd1, 32'hFFFFFFFF, 32'd2,        32'd1,        32'hFFFFFFFE, 1'b0};
    tbl[6]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        1'b0};
    tbl[7]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    tbl[8]  = '{3'd3, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0};
    tbl[9]  = '{3'd2, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
    tbl[10] = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        1'b0};
    tbl[11] = '{3'd3, 32'd3,        32'd5,        32'd3,        32'd0,        1'b0};

    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_div0", {63'd0, div0}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b);
      chk("tbl_hi", {32'd0, hi}, {32'd0, tbl[i].hi});
      chk("tbl_lo", {32'd0, lo}, {32'd0, tbl[i].lo});
      chk("tbl_div0", {63'd0, div0}, {63'd0, tbl[i].d0});
    end

    mt(3'd4, 32'hDEADBEEF);
    chk("mthi_value", {32'd0, hi}, 64'hDEADBEEF);

    @(negedge clk);
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; op = 3'd5; a = 32'h12345678;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(posedge clk); #1;
    end
    model(3'd3, 32'd100, 32'd7);
    chk("mtlo_busy_done", {63'd0, done}, 64'd1);
    chk("mtlo_busy_lo", {32'd0, lo}, 64'd14);
    chk("mtlo_busy_hi", {32'd0, hi}, 64'd2);

    ign(3'd6);
    ign(3'd7);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  o;
      logic [31:0] x, y;
      o = 3'($urandom_range(0, 7));
      x = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 300));
      y = ($urandom_range(0, 5) == 0) ? 32'd0 :
          ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 20));
      if ($urandom_range(0, 3) == 0) y = -y;
      if (o <= 3'd3) do_op(o, x, y);
      else if (o <= 3'd5) mt(o, x);
      else ign(o);
    end

    mt(3'd4, 32'hCAFEF00D);
    @(negedge clk);
    start = 1'b1; op = 3'd1; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_rst_busy", {63'd0, busy}, 64'd0);
    chk("midrun_rst_hilo", {hi, lo}, 64'd0);
    chk("midrun_rst_div0", {63'd0, div0}, 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("midrun_rst_no_done", {63'd0, done}, 64'd0);
    end
    hi_m = '0; lo_m = '0; d0_m = 1'b0;
    #1 rst_n = 1'b1;
    do_op(3'd1, 32'd2, 32'd3);
    chk("post_rst_lo", {32'd0, lo}, 64'd6);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      chk("post_rst_no_stray_done", {63'd0, done}, 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_hilo.md
MULDIV_HILO -- requirements
Module: muldiv_hilo

Interface
- REQ-001 SHALL provide parameter ITER, default 32, meaning the number of iterations per multiply or divide.
- REQ-002 SHALL provide port clk, input, 1 bit: the single clock; every flop is rising-edge.
- REQ-003 SHALL provide port rst_n, input, 1 bit: asynchronous, active-low reset.
- REQ-004 SHALL provide port start, input, 1 bit: request pulse, sampled only in IDLE.
- REQ-005 SHALL provide port op, input, 3 bits: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; codes 6-7 are ignored.
- REQ-006 SHALL provide port a, input, 32 bits: multiplicand, dividend, or MTHI/MTLO source.
- REQ-007 SHALL provide port b, input, 32 bits: multiplier or divisor.
- REQ-008 SHALL provide port busy, output, 1 bit: operation in progress; the CPU stalls on it.
- REQ-009 SHALL provide port done, output, 1 bit: one-cycle completion pulse.
- REQ-010 SHALL provide port div0, output, 1 bit: set by a divide with b==0; cleared by the next accepted start.
- REQ-011 SHALL provide port hi, output, 32 bits: HI register, which feeds the writeback 32-bit mux data input.
- REQ-012 SHALL provide port lo, output, 32 bits: LO register, which feeds the writeback 32-bit mux data input.

Function
- REQ-013 SHALL implement states IDLE, RUN and FIX; transitions: IDLE->RUN on start with op 0-3; RUN->FIX after ITER cycles; FIX->IDLE unconditionally.
- REQ-014 SHALL, in IDLE, write hi<=a in one cycle on start with op=4, and write lo<=a on start with op=5; the FSM stays in IDLE, with no busy and no done.
- REQ-015 SHALL drive busy=1 throughout RUN and FIX; start is ignored while busy.
- REQ-016 SHALL implement MULT/MULTU as shift-add on operand magnitudes (MULTU uses raw operands), one bit per RUN cycle, with {hi,lo}=64-bit product.
- REQ-017 SHALL implement DIV/DIVU as radix-2 restoring division on magnitudes, one quotient bit per RUN cycle, giving lo=quotient and hi=remainder.
- REQ-018 SHALL, in FIX, negate the product when signed operand signs differ, negate the quotient when signed signs differ, and give the signed remainder the dividend's sign.
- REQ-019 SHALL update hi/lo only on the FIX edge; hi/lo hold their old values throughout RUN.
- REQ-020 SHALL assert done for exactly the one cycle after the FIX edge; for a start edge at t0, hi/lo update at t0+ITER+1.
- REQ-021 SHALL, on a divide with b==0, run the full latency and produce lo=32'hFFFFFFFF, hi=a, div0=1.
- REQ-022 SHALL, for DIV of 32'h80000000 by 32'hFFFFFFFF, produce lo=32'h80000000 and hi=0 with no trap.
- REQ-023 SHALL capture operands and op on the accepted start edge, so later changes to a, b or op do not affect the result.

Reset
- REQ-024 SHALL, on rst_n=0, immediately force state=IDLE, busy=0, done=0, div0=0, hi=0, lo=0, and clear the iteration counter.
- REQ-025 SHALL, when reset occurs mid-RUN, discard the operation with no done pulse, and accept start again on the first edge after release.

Configuration
- REQ-026 SHALL support macro MULDIV_FAST_MUL_EN: when defined, MULT/MULTU compute a combinational 64-bit product, skip RUN (IDLE->FIX), and update hi/lo at t0+1.
- REQ-027 SHALL, when MULDIV_FAST_MUL_EN is undefined, use iterative multiply per REQ-016; divide is iterative in both builds.

Structure
- REQ-028 SHALL place the op encodings, state encoding and ITER default in shared package muldiv_pkg.
- REQ-029 SHALL implement one restoring-divide iteration (remainder/quotient shift-subtract) as sub-module div_step, instantiated once.

Verification
- REQ-030 SHALL cover: MULT a=-3, b=7 -> after ITER+1 edges hi=32'hFFFFFFFF, lo=32'hFFFFFFEB, done pulse 1 cycle.
- REQ-031 SHALL cover: DIVU a=100, b=7 -> lo=14, hi=2; DIV a=-7, b=2 -> lo=-3, hi=-1.
- REQ-032 SHALL cover: DIV a=5, b=0 -> lo=32'hFFFFFFFF, hi=5, div0=1; the next start clears div0.
- REQ-033 SHALL cover: MTHI a=32'hDEADBEEF in IDLE -> hi updated next edge, busy stays 0; MTLO issued while busy -> ignored, lo unchanged.
- REQ-034 SHALL cover: rst_n low at RUN cycle 10 -> busy=0, hi=lo=0 immediately, no done; a new MULTU 2x3 then gives lo=6.
- REQ-035 SHALL cover: with MULDIV_FAST_MUL_EN, MULTU 32'hFFFFFFFF x 2 -> hi=1, lo=32'hFFFFFFFE at t0+1.
